// File: rtl/example_pkg.sv
// ============================================================================
// example_pkg : shared constants and types for the pipelined multiplier
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ns
`default_nettype none

package example_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CLK_PERIOD_NS = 10;
  localparam int PIPE_LATENCY  = 2;

  typedef logic [DEFAULT_WIDTH-1:0]   operand_t;
  typedef logic [2*DEFAULT_WIDTH-1:0] product_t;

  // Width of the low slice of y; an odd width leaves the extra bit in the high slice.
  function automatic int split_lo(input int width);
    return width / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/example_partial_mul.sv
// ============================================================================
// example_partial_mul : combinational A_WIDTH x B_WIDTH unsigned multiplier
// Revision            : 1.0
// ============================================================================
`timescale 1ns/1ns
`default_nettype none

module example_partial_mul
  import example_pkg::*;
#(
  parameter int A_WIDTH = DEFAULT_WIDTH,
  parameter int B_WIDTH = DEFAULT_WIDTH / 2
) (
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  output logic [A_WIDTH+B_WIDTH-1:0] p
);

  assign p = {{B_WIDTH{1'b0}}, a} * {{A_WIDTH{1'b0}}, b};

endmodule

`default_nettype wire

// File: rtl/example_dut.sv
// ============================================================================
// example_dut : two-stage pipelined unsigned multiplier, z = x*y two edges late
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ns
`default_nettype none

module example_dut
  import example_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] z
);

  localparam int LO_W = split_lo(WIDTH);
  localparam int HI_W = WIDTH - LO_W;

  logic [WIDTH-1:0]      r_x;
  logic [WIDTH-1:0]      r_y;
  logic [WIDTH+LO_W-1:0] w_pp_lo;
  logic [WIDTH+HI_W-1:0] w_pp_hi;
  logic [WIDTH+LO_W-1:0] r_pp_lo;
  logic [WIDTH+HI_W-1:0] r_pp_hi;
  logic [2*WIDTH-1:0]    w_sum;

  example_partial_mul #(
    .A_WIDTH (WIDTH),
    .B_WIDTH (LO_W)
  ) u_pp_lo (
    .a (r_x),
    .b (r_y[LO_W-1:0]),
    .p (w_pp_lo)
  );

  example_partial_mul #(
    .A_WIDTH (WIDTH),
    .B_WIDTH (HI_W)
  ) u_pp_hi (
    .a (r_x),
    .b (r_y[WIDTH-1:LO_W]),
    .p (w_pp_hi)
  );

  // Both partials are zero-extended to the full product width before the shift,
  // so the sum can never wrap.
  assign w_sum = {{HI_W{1'b0}}, r_pp_lo}
               + ({{LO_W{1'b0}}, r_pp_hi} << LO_W);

  // Stage 1: operand capture and partial-product capture.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_x     <= '0;
      r_y     <= '0;
      r_pp_lo <= '0;
      r_pp_hi <= '0;
    end else begin
      r_x     <= x;
      r_y     <= y;
      r_pp_lo <= w_pp_lo;
      r_pp_hi <= w_pp_hi;
    end
  end

  // Stage 2: recombine partials into the registered product.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      z <= '0;
    end else begin
      z <= w_sum;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_example_dut.sv
// ============================================================================
// tb_example_dut : directed self-checking bench for example_dut (WIDTH 8 and 5)
// Revision       : 1.0
// ============================================================================
`timescale 1ns/1ns
`default_nettype none

module tb_example_dut;
  import example_pkg::*;

  logic     clk = 1'b0;
  logic     rstn;
  operand_t x;
  operand_t y;
  product_t z;

  logic [4:0] x5;
  logic [4:0] y5;
  logic [9:0] z5;

  int n_tests = 0;
  int n_fail  = 0;

  always #(CLK_PERIOD_NS / 2) clk = ~clk;

  example_dut #(.WIDTH(8)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .x    (x),
    .y    (y),
    .z    (z)
  );

  example_dut #(.WIDTH(5)) u_dut5 (
    .clk  (clk),
    .rstn (rstn),
    .x    (x5),
    .y    (y5),
    .z    (z5)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: z=0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply a pair, clock it in, then check z against the product from two pairs earlier.
  task automatic step(input logic [7:0] xa, input logic [7:0] ya,
                      input logic [15:0] exp, input string tag);
    x = xa;
    y = ya;
    @(posedge clk);
    #1;
    check(tag, z, exp);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] h_old;
    logic [15:0] h_new;

    x    = 8'hAA;
    y    = 8'h55;
    x5   = 5'd31;
    y5   = 5'd31;
    rstn = 1'b0;
    #1 rstn = 1'b1;
    #1;
    check("rst_z", z, 16'h0000);
    check("rst_z5", {6'd0, z5}, 16'd0);

    for (int i = 0; i < 3; i++) step(8'hAA, 8'h55, 16'h0000, "rst_hold");
    rstn = 1'b0;

    step(8'hAA, 8'h55, 16'h0000, "rel_0a");
    step(8'hAA, 8'h55, 16'h0000, "rel_0b");
    step(8'hAA, 8'h55, 16'h3872, "rel_first");

    step(8'd3,   8'd4,   16'h3872, "s_3872a");
    step(8'd7,   8'd9,   16'h3872, "s_3872b");
    step(8'd0,   8'd200, 16'd12,   "s_3x4");
    step(8'd255, 8'd1,   16'd63,   "s_7x9");
    step(8'hFF,  8'hFF,  16'd0,    "s_0x200");
    step(8'hFF,  8'h80,  16'd255,  "s_255x1");
    step(8'd12,  8'd12,  16'hFE01, "max_ff_ff");
    step(8'd10,  8'd10,  16'h7F80, "max_ff_80");
    step(8'd20,  8'd20,  16'd144,  "s_12x12");

    // (10,10) and (20,20) are now in flight; reset between edges.
    #2 rstn = 1'b1;
    #1;
    check("rst_async", z, 16'h0000);
    step(8'd30, 8'd30, 16'h0000, "rst_edge");
    rstn = 1'b0;
    step(8'd5, 8'd6, 16'h0000, "resume_0a");
    step(8'd7, 8'd7, 16'h0000, "resume_0b");
    step(8'd0, 8'd0, 16'd30,   "resume_5x6");
    step(8'd0, 8'd0, 16'd49,   "resume_7x7");

    h_old = 16'd0;
    h_new = 16'd0;
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom_range(0, 255));
      b = 16'($urandom_range(0, 255));
      step(a[7:0], b[7:0], h_old, "rand");
      h_old = h_new;
      h_new = a * b;
    end

    check("w5_31x31", {6'd0, z5}, 16'd961);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/example_dut.md
# example_dut

Two-stage pipelined unsigned multiplier at the centre of the co-emulation proof-of-concept. It takes two operands on `x` and `y` every clock and presents their full-width product on `z` a fixed two cycles later. The block is driven by the stimulus driver and observed by the monitor/checker through the shared `example_if` interface. Both sides are cycle-locked to the single clock.

## Interface
Parameters:
- `WIDTH`, 8, operand width in bits; legal range 2–32.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-high reset (asserted = 1) despite the legacy name; clears all pipeline state immediately.
- `x`  in  WIDTH  operand A, unsigned, sampled every cycle.
- `y`  in  WIDTH  operand B, unsigned, sampled every cycle.
- `z`  out  2*WIDTH  product x*y, unsigned, registered output.

`example_if` bundles `clk`, `rstn`, `x`, `y` and `z` with the same widths. It generates `clk` at a 10 ns period (5 ns high, 5 ns low), with a 1 ns / 1 ns timescale.

## Operation
- No handshake. Every rising edge accepts a new operand pair, and every edge retires one product.
- Stage 1 (edge n):
  - Register `x` and `y`.
  - Form the two half products: low half of `y` times `x`, and high half of `y` times `x`.
  - Store both in a pipeline register.
- Stage 2 (edge n+1): add the shifted high partial product to the low partial product, then register the result into `z`.
- Arithmetic is exact. `z` is 2*WIDTH bits, so no overflow, truncation or saturation is possible.
- Split `y` at `WIDTH/2`. If WIDTH is odd, the high half gets the extra bit.
- Reset: all stage registers and `z` are forced to 0 while `rstn` = 1, regardless of the clock. The pipeline refills normally after release.
- Reset mid-operation: products in flight are discarded, not completed.
- X/Z on the inputs propagates. There is no input masking.

## Timing
- Latency is exactly 2 rising edges: operands present at edge n appear on `z` just after edge n+2. Throughput is 1 result per cycle.
- `z` changes only on a rising edge or on reset assertion.
- Reset values: `z` = 0, both internal stages = 0.
- After reset release at edge r:
  - `z` stays 0 through edge r+1.
  - The first valid product is the pair sampled at edge r+1, appearing after edge r+3.
  - Outputs before that point are 0, not X.
- Boundary operands:
  - 0*anything = 0.
  - (2^WIDTH−1)^2 = 2^(2W) − 2^(W+1) + 1, which is 0xFE01 for WIDTH=8 and must be produced without wrap.
- Input setup is sampled at the rising edge. The driver changes inputs on the falling edge, or ≥1 ns after the rising edge.

## Structure
- Package `example_pkg`:
  - `DEFAULT_WIDTH` = 8.
  - `CLK_PERIOD_NS` = 10.
  - typedef `operand_t` (logic [DEFAULT_WIDTH-1:0]).
  - typedef `product_t` (logic [2*DEFAULT_WIDTH-1:0]).
  - Latency constant `PIPE_LATENCY` = 2, used by the checker for alignment.
- One sub-module is natural: `example_partial_mul`. It is a combinational WIDTH × (WIDTH/2) unsigned multiplier, instantiated twice in stage 1.
- `example_if` holds the clock generator and the default reset pulse.

## Test plan
- Reset: hold `rstn`=1 for 3 cycles with x=0xAA, y=0x55 → `z` = 0x0000 throughout; `z` = 0 for 2 cycles after release, then 0x3872.
- Basic stream: (3,4), (7,9), (0,200), (255,1) on consecutive edges → `z` = 12, 63, 0, 255 on edges n+2..n+5, back-to-back.
- Max operands: x=y=0xFF → `z` = 0xFE01 two edges later; x=0xFF, y=0x80 → 0x7F80.
- Reset mid-stream: assert `rstn` asynchronously between edges while (10,10) and (20,20) are in flight → `z` drops to 0 immediately, neither 100 nor 400 ever appears, and the stream resumes correctly after release.
- Random regression: 10 000 random pairs → the checker compares `z` against x*y delayed by `PIPE_LATENCY`, with zero mismatches.
- Parameter sweep: WIDTH=5 (odd split), x=y=31 → `z` = 961.
